rsa_modexp: RTL and testbench

Sequential 6-bit modular exponentiation engine computing data_out = msg^exp mod modulus for the RSA datapath. It sits directly upstream of the result-capture stage: that stage samples `data_out` while `Done` is high and clears its output when `Done` falls. The engine uses left-to-right square-and-multiply built on a bit-serial interleaved modular multiplier, with one multiplier step per clock.

---
 rtl/rsa_modexp.sv | 108 ++++++++++
 tb/tb_rsa_modexp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rsa_modexp.sv
// rsa_modexp: 6-bit left-to-right square-and-multiply modular exponentiation, one multiplier step per clock.
// Define RSA_MODEXP_SKIP_LZ_EN to skip leading zero exponent bits (data-dependent latency).
module rsa_modexp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] msg,
  input  logic [5:0] exp,
  input  logic [5:0] modulus,
  output logic [5:0] data_out,
  output logic       Done,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQR, S_MUL, S_DONE} state_t;
  state_t r_state, w_next;
  logic [5:0] r_m, r_e, r_n, r_acc, r_t, r_p, r_out;
  logic [2:0] r_j, r_i, w_top;
  logic       r_err, w_bad, w_zero, w_last;
  logic [5:0] w_a, w_b, w_acc;
  logic [6:0] w_d, w_dr, w_s, w_sr;
  assign w_bad = (r_n < 6'd2) || (r_m >= r_n);
`ifdef RSA_MODEXP_SKIP_LZ_EN
  always_comb begin
    w_top = 3'd0;
    for (int k = 0; k < 6; k++) if (r_e[k]) w_top = k[2:0];
  end
  assign w_zero = (r_e == 6'd0);
`else
  assign w_top  = 3'd5;
  assign w_zero = 1'b0;
`endif
  // Interleaved multiplier step: double-and-reduce, then conditional add-and-reduce, in one cycle
  assign w_a    = (r_state == S_MUL) ? r_t : r_acc;
  assign w_b    = (r_state == S_MUL) ? r_m : r_acc;
  assign w_d    = {r_p, 1'b0};
  assign w_dr   = (w_d >= {1'b0, r_n}) ? w_d - {1'b0, r_n} : w_d;
  assign w_s    = w_dr + (w_b[r_j] ? {1'b0, w_a} : 7'd0);
  assign w_sr   = (w_s >= {1'b0, r_n}) ? w_s - {1'b0, r_n} : w_s;
  assign w_last = (r_j == 3'd0);
  assign w_acc  = r_e[r_i] ? w_sr[5:0] : r_t;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = (w_bad || w_zero) ? S_DONE : S_SQR;
      S_SQR:   w_next = w_last ? S_MUL : S_SQR;
      S_MUL:   w_next = w_last ? ((r_i == 3'd0) ? S_DONE : S_SQR) : S_MUL;
      S_DONE:  w_next = start ? S_LOAD : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    Done     = (r_state == S_DONE);
    busy     = (r_state == S_LOAD) || (r_state == S_SQR) || (r_state == S_MUL);
    data_out = r_out;
    err      = r_err;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m   <= '0;
      r_e   <= '0;
      r_n   <= '0;
      r_acc <= '0;
      r_t   <= '0;
      r_p   <= '0;
      r_out <= '0;
      r_j   <= '0;
      r_i   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_m   <= msg;
          r_e   <= exp;
          r_n   <= modulus;
          r_acc <= 6'd1;
          r_out <= '0;
          r_err <= 1'b0;
        end
        S_LOAD: begin
          r_p <= '0;
          r_j <= 3'd5;
          r_i <= w_top;
          if (w_bad) r_err <= 1'b1;
          else if (w_zero) r_out <= 6'd1;
        end
        S_SQR: begin
          r_p <= w_last ? 6'd0 : w_sr[5:0];
          r_j <= w_last ? 3'd5 : r_j - 3'd1;
          if (w_last) r_t <= w_sr[5:0];
        end
        S_MUL: begin
          r_p <= w_last ? 6'd0 : w_sr[5:0];
          r_j <= w_last ? 3'd5 : r_j - 3'd1;
          if (w_last) begin
            r_acc <= w_acc;
            r_i   <= r_i - 3'd1;
            if (r_i == 3'd0) r_out <= w_acc;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: scoreboard bench for rsa_modexp against a repeated-multiplication reference model.
module tb_rsa_modexp;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0] msg = '0, exp = '0, modulus = '0;
  logic [5:0] data_out;
  logic       Done, busy, err;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int out; int er; int lat; int t0;} exp_t;
  exp_t sb[$];
  rsa_modexp dut (.clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .exp(exp),
                  .modulus(modulus), .data_out(data_out), .Done(Done), .busy(busy), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic void model(input int m, input int e, input int n, output int o, output int er, output int l);
    if (n < 2 || m >= n) begin
      o = 0; er = 1; l = 1;
    end else begin
      o = 1;
      for (int k = 0; k < e; k++) o = (o * m) % n;
      er = 0;
`ifdef RSA_MODEXP_SKIP_LZ_EN
      l = 1 + 12 * $clog2(e + 1);
`else
      l = 73;
`endif
    end
  endfunction
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (Done && !prev_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("data_out", int'(data_out), x.out);
        chk("err", int'(err), x.er);
        chk("latency", cyc - x.t0, x.lat);
      end
    end
    prev_done = Done;
  end
  task automatic issue(input int m, input int e, input int n);
    exp_t x;
    @(negedge clk);
    msg = m[5:0]; exp = e[5:0]; modulus = n[5:0]; start = 1'b1;
    model(m, e, n, x.out, x.er, x.lat);
    x.t0 = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    chk("accept_done_low", int'(Done), 0);
    chk("accept_out_zero", int'(data_out), 0);
    chk("accept_err_zero", int'(err), 0);
    chk("accept_busy", int'(busy), 1);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!Done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!Done) chk("done_timeout", 0, 1);
  endtask
  task automatic run(input int m, input int e, input int n);
    issue(m, e, n);
    wait_done();
  endtask
  initial begin
    int m, e, n, held;
    #1;
    chk("reset_done", int'(Done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out", int'(data_out), 0);
    chk("reset_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(5, 3, 33);
    run(26, 7, 33);
    run(62, 63, 63);
    run(9, 0, 55);
    run(40, 0, 33);
    run(40, 5, 33);
    run(3, 5, 1);
    run(7, 5, 33);
    issue(5, 3, 33);
    repeat (10) @(negedge clk);
    msg = 6'd10; exp = 6'd9; modulus = 6'd47; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    held = int'(data_out);
    chk("held_value", held, 26);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_stable", int'(data_out), held);
      chk("hold_done", int'(Done), 1);
    end
    issue(5, 3, 33);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_done", int'(Done), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_out", int'(data_out), 0);
    chk("async_rst_err", int'(err), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 3, 33);
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 63);
      m = ($urandom_range(0, 7) == 0 || n < 2) ? $urandom_range(0, 63) : $urandom_range(0, n - 1);
      e = $urandom_range(0, 63);
      run(m, e, n);
    end
    issue(11, 13, 59);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_low", int'(Done), 0);
    chk("b2b_busy", int'(busy), 1);
    begin
      exp_t x;
      model(11, 13, 59, x.out, x.er, x.lat);
      x.t0 = cyc;
      sb.push_back(x);
    end
    wait_done();
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
